// File: rtl/burst_sync_pkg.sv
// Shared types and constants for the burst synchroniser.
//   state_t    : controller states
//   MODE_*     : encodings of the mode input
//   BCW        : burst counter width
//   sat_inc()  : saturating increment for the burst counter
package burst_sync_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    MESSAGE,
    HOLDOFF
  } state_t;

  localparam logic MODE_PEAK  = 1'b0;
  localparam logic MODE_FIRST = 1'b1;

  localparam int unsigned BCW = 16;

  function automatic logic [BCW-1:0] sat_inc(input logic [BCW-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/burst_sync_peak_tracker.sv
// Running maximum of the correlator magnitude over the search window.
//   clk, reset : sample clock, asynchronous active-high reset
//   load       : start a new window with corr at offset 0
//   update     : compare corr (at offset win_cnt) against the held maximum
//   corr       : correlator magnitude
//   win_cnt    : window offset of the current sample
//   max_val    : largest magnitude seen so far in the window
//   idx        : window offset of max_val (earliest one on ties)
module peak_tracker
  import burst_sync_pkg::*;
#(
  parameter int CW = 20,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          update,
  input  logic [CW-1:0] corr,
  input  logic [AW-1:0] win_cnt,
  output logic [CW-1:0] max_val,
  output logic [AW-1:0] idx
);

  // Strict compare keeps the earliest sample when magnitudes tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      max_val <= '0;
      idx     <= '0;
    end else if (load) begin
      max_val <= corr;
      idx     <= '0;
    end else if (update && (corr > max_val)) begin
      max_val <= corr;
      idx     <= win_cnt;
    end
  end

endmodule

// File: rtl/burst_sync.sv
// Burst synchroniser: qualifies correlator output against a threshold,
// locates the preamble peak (peak-in-window or first-crossing), then issues
// the symbol-timing strobe, the message gate and a hold-off period.
//   clk, reset   : decimated sample clock, asynchronous active-high reset
//   sample_en    : corr/thresh valid; FSM and counters advance only then
//   clear        : synchronous abort to IDLE on any cycle
//   mode         : 0 peak-in-window, 1 first-crossing; latched leaving IDLE
//   corr, thresh : unsigned correlator magnitude and detection threshold
//   strobe       : one-clk pulse, one clk after the deciding sample
//   ena_message  : message gate for the demodulator/decoder
//   peak_val     : captured peak magnitude (updated with strobe)
//   peak_age     : samples between the peak sample and the deciding sample
//   busy         : controller outside IDLE
//   burst_cnt    : saturating count of strobes
module burst_sync
  import burst_sync_pkg::*;
#(
  parameter int CW       = 20,
  parameter int WIN_LEN  = 8,
  parameter int MSG_LEN  = 204,
  parameter int HOLD_LEN = 16,
  parameter int AW       = $clog2(WIN_LEN)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           sample_en,
  input  logic           clear,
  input  logic           mode,
  input  logic [CW-1:0]  corr,
  input  logic [CW-1:0]  thresh,
  output logic           strobe,
  output logic           ena_message,
  output logic [CW-1:0]  peak_val,
  output logic [AW-1:0]  peak_age,
  output logic           busy,
  output logic [BCW-1:0] burst_cnt
);

  localparam int MW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam int HW = (HOLD_LEN > 1) ? $clog2(HOLD_LEN) : 1;
  localparam logic [AW-1:0] WIN_LAST  = AW'(WIN_LEN - 1);
  localparam logic [MW-1:0] MSG_LAST  = MW'(MSG_LEN - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'((HOLD_LEN > 0) ? HOLD_LEN - 1 : 0);

  state_t        state, state_n;
  logic          mode_q, mode_n;
  logic          pend_q, pend_n;   // peak decided; strobe due on the next clk
  logic          last_q, last_n;   // final message sample seen; gate drops next clk
  logic [AW-1:0] win_cnt, win_cnt_n;
  logic [MW-1:0] msg_cnt, msg_cnt_n;
  logic [HW-1:0] hold_cnt, hold_cnt_n;
  logic          strobe_n, ena_n;
  logic          trk_load, trk_update;
  logic [CW-1:0] max_val;
  logic [AW-1:0] idx;
  logic          detect;

  assign detect = corr > thresh;

  peak_tracker #(
    .CW (CW),
    .AW (AW)
  ) u_peak_tracker (
    .clk     (clk),
    .reset   (reset),
    .load    (trk_load),
    .update  (trk_update),
    .corr    (corr),
    .win_cnt (win_cnt),
    .max_val (max_val),
    .idx     (idx)
  );

  always_comb begin
    state_n    = state;
    mode_n     = mode_q;
    pend_n     = pend_q;
    last_n     = last_q;
    win_cnt_n  = win_cnt;
    msg_cnt_n  = msg_cnt;
    hold_cnt_n = hold_cnt;
    strobe_n   = 1'b0;
    ena_n      = ena_message;
    trk_load   = 1'b0;
    trk_update = 1'b0;

    if (clear) begin
      state_n    = IDLE;
      pend_n     = 1'b0;
      last_n     = 1'b0;
      win_cnt_n  = '0;
      msg_cnt_n  = '0;
      hold_cnt_n = '0;
      ena_n      = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (sample_en && detect) begin
            trk_load  = 1'b1;
            mode_n    = mode;
            win_cnt_n = AW'(1);
            if (mode == MODE_FIRST) begin
              state_n = MESSAGE;
              pend_n  = 1'b1;
            end else begin
              state_n = SEARCH;
            end
          end
        end
        SEARCH: begin
          if (sample_en) begin
            trk_update = 1'b1;
            win_cnt_n  = win_cnt + 1'b1;
            if (win_cnt == WIN_LAST) begin
              state_n   = MESSAGE;
              pend_n    = 1'b1;
              win_cnt_n = '0;
            end
          end
        end
        MESSAGE: begin
          // The strobe and gate-drop cycles are clock-timed, so a sample_en
          // on those cycles is neither counted nor needed.
          if (pend_q) begin
            pend_n   = 1'b0;
            strobe_n = 1'b1;
            ena_n    = 1'b1;
          end else if (last_q) begin
            last_n    = 1'b0;
            ena_n     = 1'b0;
            msg_cnt_n = '0;
            state_n   = (HOLD_LEN == 0) ? IDLE : HOLDOFF;
          end else if (sample_en) begin
            if (msg_cnt == MSG_LAST) begin
              last_n = 1'b1;
            end else begin
              msg_cnt_n = msg_cnt + 1'b1;
            end
          end
        end
        HOLDOFF: begin
          if (sample_en) begin
            if (hold_cnt == HOLD_LAST) begin
              state_n    = IDLE;
              hold_cnt_n = '0;
            end else begin
              hold_cnt_n = hold_cnt + 1'b1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      mode_q      <= MODE_PEAK;
      pend_q      <= 1'b0;
      last_q      <= 1'b0;
      win_cnt     <= '0;
      msg_cnt     <= '0;
      hold_cnt    <= '0;
      strobe      <= 1'b0;
      ena_message <= 1'b0;
      busy        <= 1'b0;
      peak_val    <= '0;
      peak_age    <= '0;
      burst_cnt   <= '0;
    end else begin
      state       <= state_n;
      mode_q      <= mode_n;
      pend_q      <= pend_n;
      last_q      <= last_n;
      win_cnt     <= win_cnt_n;
      msg_cnt     <= msg_cnt_n;
      hold_cnt    <= hold_cnt_n;
      strobe      <= strobe_n;
      ena_message <= ena_n;
      busy        <= (state_n != IDLE);
      if (strobe_n) begin
        peak_val  <= max_val;
        peak_age  <= (mode_q == MODE_PEAK) ? WIN_LAST - idx : '0;
        burst_cnt <= sat_inc(burst_cnt);
      end
    end
  end

endmodule

// File: tb/tb_burst_sync.sv
module tb_burst_sync;
  localparam int CW = 20, WIN_LEN = 8, MSG_LEN = 16, HOLD_LEN = 4, AW = 3;
  localparam int MAXN = 600;
  localparam int STB = 41, ENA = 40, BSY = 39;

  typedef logic [41:0] obs_t; // {strobe, ena, busy, peak_val[20], peak_age[3], burst_cnt[16]}

  logic clk = 1'b0;
  logic reset, sample_en, clear, mode;
  logic [CW-1:0] corr, thresh;
  logic strobe, ena_message, busy;
  logic [CW-1:0] peak_val;
  logic [AW-1:0] peak_age;
  logic [15:0] burst_cnt;

  burst_sync #(.CW(CW), .WIN_LEN(WIN_LEN), .MSG_LEN(MSG_LEN), .HOLD_LEN(HOLD_LEN), .AW(AW)) dut (
    .clk(clk), .reset(reset), .sample_en(sample_en), .clear(clear), .mode(mode),
    .corr(corr), .thresh(thresh), .strobe(strobe), .ena_message(ena_message),
    .peak_val(peak_val), .peak_age(peak_age), .busy(busy), .burst_cnt(burst_cnt)
  );

  always #5 clk = ~clk;

  logic s_se [MAXN];
  logic s_clr [MAXN];
  logic s_mode [MAXN];
  logic [CW-1:0] s_corr [MAXN];
  logic [CW-1:0] s_th [MAXN];
  obs_t exp_o [MAXN];
  obs_t got [MAXN];
  int n_cyc;
  int base_seq [9] = '{0, 150, 300, 900, 400, 120, 50, 0, 0};

  int unsigned m_cnt = 0;
  logic [CW-1:0] m_pv = '0;
  logic [AW-1:0] m_pa = '0;
  int checks = 0;
  int failures = 0;

  task automatic stim_defaults(input int n);
    n_cyc = n;
    for (int k = 0; k < MAXN; k++) begin
      s_se[k] = 1'b1; s_clr[k] = 1'b0; s_mode[k] = 1'b0;
      s_corr[k] = '0; s_th[k] = CW'(100);
    end
  endtask

  function automatic int next_se(input int after);
    for (int j = after + 1; j < n_cyc; j++) if (s_se[j]) return j;
    return n_cyc;
  endfunction

  // Burst-level reference: find each qualifying crossing, the deciding sample,
  // then count qualified samples for the message gate and hold-off.
  task automatic build_model();
    logic st [MAXN]; logic en [MAXN]; logic bz [MAXN]; logic upd [MAXN];
    logic [CW-1:0] upv [MAXN]; logic [AW-1:0] upa [MAXN];
    logic [CW-1:0] pk;
    int k0, d, s, m, f, h, c, off, endb;
    for (int k = 0; k < MAXN; k++) begin
      st[k] = 0; en[k] = 0; bz[k] = 0; upd[k] = 0; upv[k] = '0; upa[k] = '0;
    end
    k0 = 0;
    while (k0 < n_cyc) begin
      while (k0 < n_cyc && !(s_se[k0] && !s_clr[k0] && s_corr[k0] > s_th[k0])) k0++;
      if (k0 >= n_cyc) break;
      d = k0; pk = s_corr[k0]; off = 0;
      if (!s_mode[k0]) begin
        for (int w = 1; w < WIN_LEN; w++) begin
          d = next_se(d);
          if (d < n_cyc && s_corr[d] > pk) begin pk = s_corr[d]; off = w; end
        end
      end
      s = d + 1;
      m = s; for (int i = 0; i < MSG_LEN; i++) m = next_se(m);
      f = m + 1;
      h = f; for (int i = 0; i < HOLD_LEN; i++) h = next_se(h);
      c = k0 + 1;
      while (c <= h && c < n_cyc && !s_clr[c]) c++;
      endb = (c <= h) ? c : h;
      for (int k = k0; k < endb && k < n_cyc; k++) bz[k] = 1;
      if (s < c && s < n_cyc) begin
        st[s] = 1; upd[s] = 1; upv[s] = pk;
        upa[s] = s_mode[k0] ? AW'(0) : AW'(WIN_LEN - 1 - off);
      end
      for (int k = s; k < f && k < c && k < n_cyc; k++) en[k] = 1;
      k0 = (c <= h) ? c + 1 : h + 1;
    end
    for (int k = 0; k < n_cyc; k++) begin
      if (upd[k]) begin
        m_pv = upv[k]; m_pa = upa[k];
        if (m_cnt < 32'hFFFF) m_cnt++;
      end
      exp_o[k] = {st[k], en[k], bz[k], m_pv, m_pa, m_cnt[15:0]};
    end
  endtask

  task automatic run_stim();
    for (int k = 0; k < n_cyc; k++) begin
      @(negedge clk);
      sample_en = s_se[k]; clear = s_clr[k]; mode = s_mode[k];
      corr = s_corr[k]; thresh = s_th[k];
      @(posedge clk); #1;
      got[k] = {strobe, ena_message, busy, peak_val, peak_age, burst_cnt};
    end
    @(negedge clk);
    sample_en = 1'b0; clear = 1'b0; corr = '0;
  endtask

  function automatic int count_bit(input int pos, input int from, input int to);
    int n = 0;
    for (int k = from; k <= to && k < n_cyc; k++) if (got[k][pos]) n++;
    return n;
  endfunction

  task automatic test_reset();
    reset = 1'b1; sample_en = 1'b0; clear = 1'b0; mode = 1'b0; corr = '0; thresh = CW'(100);
    @(posedge clk); #1;
    checks++;
    if ({strobe, ena_message, busy, peak_val, peak_age, burst_cnt} !== 42'd0) begin
      failures++;
      $display("FAIL reset_values got=%h exp=0", {strobe, ena_message, busy, peak_val, peak_age, burst_cnt});
    end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_peak_window();
    stim_defaults(40);
    for (int i = 0; i < 9; i++) s_corr[i] = CW'(base_seq[i]);
    build_model(); run_stim();
    for (int k = 0; k < n_cyc; k++) begin
      checks++;
      if (got[k] !== exp_o[k]) begin failures++; $display("FAIL peak_window cyc=%0d got=%h exp=%h", k, got[k], exp_o[k]); end
    end
    checks++; if (got[9][STB] !== 1'b1) begin failures++; $display("FAIL peak_window_strobe_time got=%b exp=1", got[9][STB]); end
    checks++; if (count_bit(ENA, 0, n_cyc - 1) != 17) begin failures++; $display("FAIL peak_window_ena_len got=%0d exp=17", count_bit(ENA, 0, n_cyc - 1)); end
    checks++; if (peak_val !== CW'(900) || peak_age !== 3'd5) begin failures++; $display("FAIL peak_window_peak got=%0d/%0d exp=900/5", peak_val, peak_age); end
    checks++; if (burst_cnt !== 16'd1) begin failures++; $display("FAIL peak_window_cnt got=%0d exp=1", burst_cnt); end
  endtask

  task automatic test_first_cross();
    stim_defaults(40);
    for (int i = 0; i < 9; i++) s_corr[i] = CW'(base_seq[i]);
    for (int k = 0; k < n_cyc; k++) s_mode[k] = 1'b1;
    build_model(); run_stim();
    for (int k = 0; k < n_cyc; k++) begin
      checks++;
      if (got[k] !== exp_o[k]) begin failures++; $display("FAIL first_cross cyc=%0d got=%h exp=%h", k, got[k], exp_o[k]); end
    end
    checks++; if (got[2][STB] !== 1'b1 || count_bit(STB, 0, n_cyc - 1) != 1) begin failures++; $display("FAIL first_cross_strobe got=%b/%0d exp=1/1", got[2][STB], count_bit(STB, 0, n_cyc - 1)); end
    checks++; if (peak_val !== CW'(150) || peak_age !== 3'd0 || burst_cnt !== 16'd2) begin failures++; $display("FAIL first_cross_peak got=%0d/%0d/%0d exp=150/0/2", peak_val, peak_age, burst_cnt); end
  endtask

  task automatic test_equal_holdoff();
    stim_defaults(70);
    s_corr[0] = CW'(150); s_corr[2] = CW'(500); s_corr[5] = CW'(500);
    s_corr[27] = CW'(600); s_corr[29] = CW'(600); s_corr[30] = CW'(200);
    build_model(); run_stim();
    for (int k = 0; k < n_cyc; k++) begin
      checks++;
      if (got[k] !== exp_o[k]) begin failures++; $display("FAIL equal_holdoff cyc=%0d got=%h exp=%h", k, got[k], exp_o[k]); end
    end
    checks++; if (got[8][STB] !== 1'b1 || got[8][18:16] !== 3'd5) begin failures++; $display("FAIL equal_earliest got=%b/%0d exp=1/5", got[8][STB], got[8][18:16]); end
    checks++; if (count_bit(STB, 0, n_cyc - 1) != 2 || got[38][STB] !== 1'b1) begin failures++; $display("FAIL holdoff_rearm got=%0d/%b exp=2/1", count_bit(STB, 0, n_cyc - 1), got[38][STB]); end
  endtask

  task automatic test_decimated();
    stim_defaults(120);
    for (int k = 0; k < n_cyc; k++) begin
      s_se[k] = (k % 4 == 0);
      if (k % 4 == 0) s_corr[k] = (k / 4 < 9) ? CW'(base_seq[k / 4]) : '0;
      else begin s_corr[k] = CW'($urandom_range(1000, 0)); s_th[k] = CW'($urandom_range(200, 0)); end
    end
    build_model(); run_stim();
    for (int k = 0; k < n_cyc; k++) begin
      checks++;
      if (got[k] !== exp_o[k]) begin failures++; $display("FAIL decimated cyc=%0d got=%h exp=%h", k, got[k], exp_o[k]); end
    end
    checks++; if (got[33][STB] !== 1'b1 || count_bit(STB, 0, n_cyc - 1) != 1) begin failures++; $display("FAIL decimated_strobe got=%b/%0d exp=1/1", got[33][STB], count_bit(STB, 0, n_cyc - 1)); end
    checks++; if (count_bit(ENA, 0, n_cyc - 1) != 64) begin failures++; $display("FAIL decimated_ena_len got=%0d exp=64", count_bit(ENA, 0, n_cyc - 1)); end
  endtask

  task automatic test_clear();
    stim_defaults(30);
    s_corr[2] = CW'(300); s_clr[5] = 1'b1;
    s_corr[10] = CW'(300); s_mode[10] = 1'b1; s_clr[11] = 1'b1;
    s_corr[15] = CW'(300); s_mode[15] = 1'b1; s_clr[22] = 1'b1;
    build_model(); run_stim();
    for (int k = 0; k < n_cyc; k++) begin
      checks++;
      if (got[k] !== exp_o[k]) begin failures++; $display("FAIL clear cyc=%0d got=%h exp=%h", k, got[k], exp_o[k]); end
    end
    checks++; if (count_bit(STB, 0, 14) != 0) begin failures++; $display("FAIL clear_no_strobe got=%0d exp=0", count_bit(STB, 0, 14)); end
    checks++; if (got[22][ENA] !== 1'b0 || got[22][BSY] !== 1'b0 || got[21][ENA] !== 1'b1) begin failures++; $display("FAIL clear_mid_message got=%b%b%b exp=001", got[22][ENA], got[22][BSY], got[21][ENA]); end
  endtask

  task automatic test_random();
    int unsigned dens;
    for (int r = 0; r < 2; r++) begin
      dens = (r == 0) ? 1 : 3;
      stim_defaults(500);
      for (int k = 0; k < n_cyc; k++) begin
        s_se[k] = ($urandom_range(dens - 1, 0) == 0);
        s_clr[k] = ($urandom_range(79, 0) == 0);
        s_mode[k] = 1'($urandom_range(1, 0));
        s_corr[k] = CW'($urandom_range(250, 0));
        s_th[k] = CW'($urandom_range(160, 80));
      end
      s_clr[n_cyc - 1] = 1'b1;
      build_model(); run_stim();
      for (int k = 0; k < n_cyc; k++) begin
        checks++;
        if (got[k] !== exp_o[k]) begin failures++; $display("FAIL random%0d cyc=%0d got=%h exp=%h", r, k, got[k], exp_o[k]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    stim_defaults(5);
    for (int k = 0; k < n_cyc; k++) s_mode[k] = 1'b1;
    s_corr[1] = CW'(500);
    build_model(); run_stim();
    for (int k = 0; k < n_cyc; k++) begin
      checks++;
      if (got[k] !== exp_o[k]) begin failures++; $display("FAIL reset_mid_pre cyc=%0d got=%h exp=%h", k, got[k], exp_o[k]); end
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({strobe, ena_message, busy, peak_val, peak_age, burst_cnt} !== 42'd0) begin
      failures++;
      $display("FAIL reset_mid_async got=%h exp=0", {strobe, ena_message, busy, peak_val, peak_age, burst_cnt});
    end
    @(posedge clk); @(negedge clk); reset = 1'b0;
    m_cnt = 0; m_pv = '0; m_pa = '0;
  endtask

  task automatic test_saturate();
    @(negedge clk);
    force dut.burst_cnt = 16'hFFFE;
    @(posedge clk); #1;
    release dut.burst_cnt;
    m_cnt = 32'hFFFE;
    stim_defaults(80);
    for (int k = 0; k < n_cyc; k++) s_mode[k] = 1'b1;
    s_corr[0] = CW'(200); s_corr[25] = CW'(200); s_corr[50] = CW'(200);
    build_model(); run_stim();
    for (int k = 0; k < n_cyc; k++) begin
      checks++;
      if (got[k] !== exp_o[k]) begin failures++; $display("FAIL saturate cyc=%0d got=%h exp=%h", k, got[k], exp_o[k]); end
    end
    checks++; if (count_bit(STB, 0, n_cyc - 1) != 3 || burst_cnt !== 16'hFFFF) begin failures++; $display("FAIL saturate_final got=%0d/%h exp=3/ffff", count_bit(STB, 0, n_cyc - 1), burst_cnt); end
  endtask

  initial begin
    test_reset();
    test_peak_window();
    test_first_cross();
    test_equal_holdoff();
    test_decimated();
    test_clear();
    test_random();
    test_reset_mid();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
